// File: rtl/fetch_unit_pkg.sv
// Shared processor package: opcode constants and the fetch state encoding,
// used by both the fetch unit and the decode controller.
package fetch_unit_pkg;

  localparam logic [5:0] OP_NOOP = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_JMP  = 6'h02;
  localparam logic [5:0] OP_JC   = 6'h03;
  localparam logic [5:0] OP_JAL  = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Drives the read address of a 1-cycle-latency synchronous instruction memory,
// tracks the address of the word currently on imem_data (instr_pc), and
// presents that word to decode, squashing it on redirects and holding it on
// stalls. A live HALT_OP stops fetching until reset.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_addr / imem_data   memory read address (comb) / data (prev. address)
//   opcode, instr           decoded opcode and full word to the datapath
//   instr_valid             opcode/instr carry a live instruction
//   jump, branch, jal       registered controls from the decode controller
//   branch_cond             branch condition (only meaningful with branch)
//   target_addr             jump/branch target
//   stall                   datapath hold request
//   link_addr               return address for JAL (instr_pc)
//   halted                  unit is in HALTED
//   fetch_count             number of issued instructions
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter logic [5:0]           HALT_OP  = OP_HALT
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [5:0]          opcode,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                jump,
  input  logic                branch,
  input  logic                jal,
  input  logic                branch_cond,
  input  logic [PC_WIDTH-1:0] target_addr,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] link_addr,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  fetch_state_t        state, state_nxt;
  logic [PC_WIDTH-1:0] instr_pc, addr_nxt;
  logic [31:0]         count;
  logic                redirect, live, issue, is_halt;

  // jal only qualifies the R14 write downstream; link_addr itself does not
  // depend on it.
  logic unused_jal;
  assign unused_jal = jal;

  // jump dominates: with jump=1 the branch term is forced to 0, so an
  // unknown branch/branch_cond cannot disturb the redirect decision.
  assign redirect = jump | (branch & branch_cond & ~jump);
  assign is_halt  = (imem_data[31:26] == HALT_OP);

  always_comb begin
    state_nxt = state;
    addr_nxt  = instr_pc;
    live      = 1'b0;
    case (state)
      ST_BOOT: begin
        addr_nxt  = RESET_PC;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          addr_nxt = target_addr;
        end else if (stall) begin
          addr_nxt = instr_pc;
        end else begin
          addr_nxt = instr_pc + 1'b1;
          live     = 1'b1;
        end
        if (live && is_halt) begin
          state_nxt = ST_HALTED;
        end
      end
      default: begin
        addr_nxt = instr_pc;
      end
    endcase
  end

  // Outputs are forced to their reset values combinationally while reset is
  // high, so nothing in flight leaks out during the reset cycle itself.
  assign issue       = live & ~reset;
  assign imem_addr   = reset ? RESET_PC : addr_nxt;
  assign instr_valid = issue;
  assign opcode      = (issue && !is_halt) ? imem_data[31:26] : OP_NOOP;
  assign instr       = issue ? imem_data : '0;
  assign halted      = (state == ST_HALTED) && !reset;
  assign link_addr   = reset ? RESET_PC : instr_pc;
  assign fetch_count = reset ? '0 : count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      instr_pc <= RESET_PC;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      instr_pc <= addr_nxt;
      if (issue) begin
        count <= count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 512-word synchronous memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [5:0]  opcode;
  logic [31:0] instr;
  logic        instr_valid;
  logic        jump, branch, jal, branch_cond, stall;
  logic [8:0]  target_addr;
  logic [8:0]  link_addr;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:511];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  fetch_unit #(
    .PC_WIDTH (9),
    .RESET_PC (9'd0),
    .HALT_OP  (6'h3F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .opcode      (opcode),
    .instr       (instr),
    .instr_valid (instr_valid),
    .jump        (jump),
    .branch      (branch),
    .jal         (jal),
    .branch_cond (branch_cond),
    .target_addr (target_addr),
    .stall       (stall),
    .link_addr   (link_addr),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jump = 1'b0; branch = 1'b0;
    branch_cond = 1'b0; jal = 1'b0; target_addr = 9'd0;
    for (int i = 0; i < 512; i++) mem[i] = {OP_ADD, 26'(i)};
    mem[5]  = {OP_JMP,  26'd0};
    mem[7]  = {OP_JC,   26'd0};
    mem[10] = {OP_JAL,  26'd0};
    mem[50] = {OP_HALT, 26'd0};

    // reset state
    tick; tick; #1;
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_op",    32'(opcode), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halt",  32'(halted), 32'd0);
    chk("rst_cnt",   fetch_count, 32'd0);
    chk("rst_link",  32'(link_addr), 32'd0);

    // BOOT
    reset = 1'b0; #1;
    chk("boot_addr",  32'(imem_addr), 32'd0);
    chk("boot_valid", 32'(instr_valid), 32'd0);

    // sequential fetch 0..3
    tick; #1;                                   // pc0
    chk("seq0_addr",  32'(imem_addr), 32'd1);
    chk("seq0_valid", 32'(instr_valid), 32'd1);
    chk("seq0_op",    32'(opcode), 32'(OP_ADD));
    chk("seq0_instr", instr, {OP_ADD, 26'd0});
    chk("seq0_cnt",   fetch_count, 32'd0);
    tick; #1;                                   // pc1
    chk("seq1_addr",  32'(imem_addr), 32'd2);
    tick; #1;                                   // pc2
    chk("seq2_addr",  32'(imem_addr), 32'd3);
    tick; #1;                                   // pc3
    chk("seq3_cnt",   fetch_count, 32'd3);
    chk("seq3_link",  32'(link_addr), 32'd3);
    tick; #1;                                   // pc4
    tick; #1;                                   // pc5
    chk("jmp_op",     32'(opcode), 32'(OP_JMP));
    chk("jmp_next",   32'(imem_addr), 32'd6);

    // JMP redirect to 40
    tick; jump = 1'b1; target_addr = 9'd40; #1; // pc6 squashed
    chk("jmp_sq_op",    32'(opcode), 32'd0);
    chk("jmp_sq_instr", instr, 32'd0);
    chk("jmp_sq_valid", 32'(instr_valid), 32'd0);
    chk("jmp_sq_addr",  32'(imem_addr), 32'd40);
    tick; jump = 1'b0; #1;                      // pc40
    chk("jmp_pc",    32'(link_addr), 32'd40);
    chk("jmp_instr", instr, {OP_ADD, 26'd40});
    chk("jmp_valid", 32'(instr_valid), 32'd1);

    // JC at 7
    tick; jump = 1'b1; target_addr = 9'd7; #1;  // pc41 squashed
    tick; jump = 1'b0; #1;                      // pc7
    chk("jc_op", 32'(opcode), 32'(OP_JC));
    tick; branch = 1'b1; branch_cond = 1'b0; target_addr = 9'd2; #1; // pc8
    chk("bnt_addr",  32'(imem_addr), 32'd9);
    chk("bnt_valid", 32'(instr_valid), 32'd1);
    tick; branch = 1'b1; branch_cond = 1'b1; #1; // pc9 taken
    chk("bt_link",  32'(link_addr), 32'd9);
    chk("bt_addr",  32'(imem_addr), 32'd2);
    chk("bt_valid", 32'(instr_valid), 32'd0);
    tick; branch = 1'b0; branch_cond = 1'b0; #1; // pc2
    chk("bt_pc",    32'(link_addr), 32'd2);
    chk("bt_instr", instr, {OP_ADD, 26'd2});
    tick; jump = 1'b1; branch = 1'bx; branch_cond = 1'bx; target_addr = 9'd7; #1; // pc3
    chk("jx_addr",  32'(imem_addr), 32'd7);
    chk("jx_valid", 32'(instr_valid), 32'd0);
    tick; jump = 1'b0; branch = 1'b0; branch_cond = 1'b0; #1; // pc7
    chk("jx_pc", 32'(link_addr), 32'd7);

    // JAL at 10
    tick; jump = 1'b1; target_addr = 9'd10; #1; // pc8 squashed
    tick; jump = 1'b0; #1;                      // pc10
    chk("jal_op", 32'(opcode), 32'(OP_JAL));
    tick; jal = 1'b1; jump = 1'b1; target_addr = 9'd100; #1; // pc11
    chk("jal_link",  32'(link_addr), 32'd11);
    chk("jal_addr",  32'(imem_addr), 32'd100);
    chk("jal_valid", 32'(instr_valid), 32'd0);
    tick; jal = 1'b0; jump = 1'b0; #1;          // pc100
    chk("jal_pc",    32'(link_addr), 32'd100);
    chk("jal_instr", instr, {OP_ADD, 26'd100});
    chk("jal_cnt",   fetch_count, 32'd12);

    // 3-cycle stall at 20, redirect on the second
    tick; jump = 1'b1; target_addr = 9'd20; #1; // pc101 squashed
    tick; jump = 1'b0; stall = 1'b1; #1;        // pc20 stall 1
    chk("st1_addr",  32'(imem_addr), 32'd20);
    chk("st1_valid", 32'(instr_valid), 32'd0);
    chk("st1_op",    32'(opcode), 32'd0);
    tick; jump = 1'b1; target_addr = 9'd30; #1; // pc20 stall 2 + redirect
    chk("st2_addr",  32'(imem_addr), 32'd30);
    chk("st2_valid", 32'(instr_valid), 32'd0);
    tick; jump = 1'b0; #1;                      // pc30 stall 3
    chk("st3_link",  32'(link_addr), 32'd30);
    chk("st3_addr",  32'(imem_addr), 32'd30);
    chk("st3_valid", 32'(instr_valid), 32'd0);
    tick; stall = 1'b0; #1;                     // pc30 issues
    chk("st_instr", instr, {OP_ADD, 26'd30});
    chk("st_valid", 32'(instr_valid), 32'd1);
    chk("st_cnt",   fetch_count, 32'd13);

    // single stall: the held word re-presents and issues once
    tick; stall = 1'b1; #1;                     // pc31 held
    chk("rp_hold_valid", 32'(instr_valid), 32'd0);
    tick; stall = 1'b0; #1;                     // pc31 again
    chk("rp_link",  32'(link_addr), 32'd31);
    chk("rp_instr", instr, {OP_ADD, 26'd31});
    tick; #1;                                   // pc32
    chk("rp_cnt", fetch_count, 32'd15);

    // stalled and squashed HALT at 50 have no effect
    tick; jump = 1'b1; target_addr = 9'd50; #1; // pc33 squashed
    tick; jump = 1'b0; stall = 1'b1; #1;        // pc50 HALT stalled
    chk("hst_op",    32'(opcode), 32'd0);
    chk("hst_valid", 32'(instr_valid), 32'd0);
    tick; stall = 1'b0; jump = 1'b1; target_addr = 9'd511; #1; // pc50 HALT squashed
    chk("hsq_valid", 32'(instr_valid), 32'd0);
    chk("hsq_addr",  32'(imem_addr), 32'd511);

    // wrap 511 -> 0, then live HALT at 0
    tick; jump = 1'b0; #1;                      // pc511
    chk("wrap_halted", 32'(halted), 32'd0);
    chk("wrap_link",   32'(link_addr), 32'd511);
    chk("wrap_addr",   32'(imem_addr), 32'd0);
    mem[0] = {OP_HALT, 26'd0};
    tick; #1;                                   // pc0 HALT live
    chk("halt_op",     32'(opcode), 32'd0);
    chk("halt_valid",  32'(instr_valid), 32'd1);
    chk("halt_pre",    32'(halted), 32'd0);
    chk("halt_addr",   32'(imem_addr), 32'd1);
    tick; stall = 1'b1; jump = 1'b1; target_addr = 9'd77; #1; // HALTED
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_op",     32'(opcode), 32'd0);
    chk("hlt_valid",  32'(instr_valid), 32'd0);
    chk("hlt_addr",   32'(imem_addr), 32'd1);
    chk("hlt_cnt",    fetch_count, 32'd18);
    tick; tick; #1;
    chk("hlt_cnt2",    fetch_count, 32'd18);
    chk("hlt_halted2", 32'(halted), 32'd1);

    // reset out of HALTED
    stall = 1'b0; jump = 1'b0; reset = 1'b1; #1;
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_cnt",    fetch_count, 32'd0);
    chk("hrst_addr",   32'(imem_addr), 32'd0);
    chk("hrst_link",   32'(link_addr), 32'd0);
    tick; reset = 1'b0; #1;                     // BOOT
    chk("hboot_halted", 32'(halted), 32'd0);
    chk("hboot_valid",  32'(instr_valid), 32'd0);
    chk("hboot_addr",   32'(imem_addr), 32'd0);
    chk("hboot_cnt",    fetch_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
